// File: rtl/rv32i_amo_unit.sv
// RV32A atomic memory operation sequencer.
// Runs AMO read-modify-write, LR.W and SC.W over a single request/ready
// memory port, holds the LR/SC reservation and returns the write-back value
// with a one-cycle done pulse. Outputs are registered, so done and rd_data
// appear in the cycle after the FSM passes through DONE.
module rv32i_amo_unit #(
   parameter int XLEN    = 32,
   parameter int ADDR_W  = 32,
   parameter bit LRSC_EN = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [4:0]        funct5,
   input  logic [ADDR_W-1:0] addr,
   input  logic [XLEN-1:0]   rs2_data,
   output logic              busy,
   output logic              done,
   output logic [XLEN-1:0]   rd_data,
   output logic              err,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [XLEN-1:0]   mem_wdata,
   input  logic [XLEN-1:0]   mem_rdata,
   input  logic              mem_ready,
   input  logic              snoop_valid,
   input  logic [ADDR_W-1:0] snoop_addr
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

   localparam logic [4:0] F_ADD  = 5'b00000;
   localparam logic [4:0] F_SWAP = 5'b00001;
   localparam logic [4:0] F_LR   = 5'b00010;
   localparam logic [4:0] F_SC   = 5'b00011;
   localparam logic [4:0] F_XOR  = 5'b00100;
   localparam logic [4:0] F_OR   = 5'b01000;
   localparam logic [4:0] F_AND  = 5'b01100;
   localparam logic [4:0] F_MIN  = 5'b10000;
   localparam logic [4:0] F_MAX  = 5'b10100;
   localparam logic [4:0] F_MINU = 5'b11000;
   localparam logic [4:0] F_MAXU = 5'b11100;

   state_t              r_state;
   logic [4:0]          r_funct5;
   logic [ADDR_W-1:0]   r_addr;
   logic [XLEN-1:0]     r_rs2;
   logic [XLEN-1:0]     r_result;
   logic                r_err;
   logic                r_busy;
   logic                r_done;
   logic                r_errOut;
   logic [XLEN-1:0]     r_rdData;
   logic                r_memReq;
   logic                r_memWe;
   logic [XLEN-1:0]     r_memWdata;
   logic                r_resValid;
   logic [ADDR_W-3:0]   r_resWord;

   logic                w_legal;
   logic                w_isSc;
   logic                w_misaligned;
   logic                w_scOk;
   logic                w_snoopHit;
   logic                w_amoWordHit;
   logic [XLEN-1:0]     w_amoResult;
   logic                w_unusedSnoopLow;

   assign w_isSc        = (funct5 == F_SC);
   assign w_misaligned  = (addr[1:0] != 2'b00);
   assign w_scOk        = r_resValid && (addr[ADDR_W-1:2] == r_resWord);
   assign w_snoopHit    = snoop_valid && r_resValid && (snoop_addr[ADDR_W-1:2] == r_resWord);
   assign w_amoWordHit  = r_resValid && (r_addr[ADDR_W-1:2] == r_resWord);
   assign w_unusedSnoopLow = ^snoop_addr[1:0];

   // Decide whether the incoming funct5 is an operation this unit supports
   always_comb begin
      w_legal = 1'b0;
      case (funct5)
         F_ADD, F_SWAP, F_XOR, F_OR, F_AND,
         F_MIN, F_MAX, F_MINU, F_MAXU: w_legal = 1'b1;
         F_LR, F_SC:                   w_legal = LRSC_EN;
         default:                      w_legal = 1'b0;
      endcase
   end

   // AMO function result from the word arriving on mem_rdata; ties keep old
   always_comb begin
      w_amoResult = r_rs2;
      case (r_funct5)
         F_ADD:  w_amoResult = mem_rdata + r_rs2;
         F_SWAP: w_amoResult = r_rs2;
         F_XOR:  w_amoResult = mem_rdata ^ r_rs2;
         F_OR:   w_amoResult = mem_rdata | r_rs2;
         F_AND:  w_amoResult = mem_rdata & r_rs2;
         F_MIN:  w_amoResult = ($signed(r_rs2) < $signed(mem_rdata)) ? r_rs2 : mem_rdata;
         F_MAX:  w_amoResult = ($signed(r_rs2) > $signed(mem_rdata)) ? r_rs2 : mem_rdata;
         F_MINU: w_amoResult = (r_rs2 < mem_rdata) ? r_rs2 : mem_rdata;
         F_MAXU: w_amoResult = (r_rs2 > mem_rdata) ? r_rs2 : mem_rdata;
         default: w_amoResult = r_rs2;
      endcase
   end

   // Sequencer FSM with registered outputs and the LR/SC reservation
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_funct5   <= '0;
         r_addr     <= '0;
         r_rs2      <= '0;
         r_result   <= '0;
         r_err      <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_errOut   <= 1'b0;
         r_rdData   <= '0;
         r_memReq   <= 1'b0;
         r_memWe    <= 1'b0;
         r_memWdata <= '0;
         r_resValid <= 1'b0;
         r_resWord  <= '0;
      end else begin
         r_done   <= 1'b0;
         r_errOut <= 1'b0;
         r_rdData <= '0;
         if (w_snoopHit) begin
            r_resValid <= 1'b0;
         end
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_funct5 <= funct5;
                  r_addr   <= addr;
                  r_rs2    <= rs2_data;
                  r_busy   <= 1'b1;
                  r_err    <= 1'b0;
                  r_result <= '0;
                  if (w_isSc) begin
                     r_resValid <= 1'b0;
                  end
                  if (w_misaligned || !w_legal) begin
                     r_err   <= 1'b1;
                     r_state <= DONE;
                  end else if (w_isSc) begin
                     if (w_scOk) begin
                        r_memReq   <= 1'b1;
                        r_memWe    <= 1'b1;
                        r_memWdata <= rs2_data;
                        r_state    <= WRITE;
                     end else begin
                        r_result <= XLEN'(1);
                        r_state  <= DONE;
                     end
                  end else begin
                     r_memReq <= 1'b1;
                     r_memWe  <= 1'b0;
                     r_state  <= READ;
                  end
               end
            end
            READ: begin
               if (mem_ready) begin
                  r_result <= mem_rdata;
                  if (r_funct5 == F_LR) begin
                     r_memReq   <= 1'b0;
                     r_resValid <= 1'b1;
                     r_resWord  <= r_addr[ADDR_W-1:2];
                     r_state    <= DONE;
                  end else begin
                     r_memWe    <= 1'b1;
                     r_memWdata <= w_amoResult;
                     r_state    <= WRITE;
                  end
               end
            end
            WRITE: begin
               if (mem_ready) begin
                  r_memReq <= 1'b0;
                  r_memWe  <= 1'b0;
                  r_state  <= DONE;
                  if (r_funct5 != F_SC && w_amoWordHit) begin
                     r_resValid <= 1'b0;
                  end
               end
            end
            DONE: begin
               r_done   <= 1'b1;
               r_errOut <= r_err;
               r_rdData <= r_err ? '0 : r_result;
               r_busy   <= 1'b0;
               r_state  <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign rd_data   = r_rdData;
   assign err       = r_errOut;
   assign mem_req   = r_memReq;
   assign mem_we    = r_memWe;
   assign mem_addr  = r_addr;
   assign mem_wdata = r_memWdata;

endmodule

// File: tb/tb_rv32i_amo_unit.sv
// Testbench for rv32i_amo_unit: directed scenarios plus a randomized run
// checked against a behavioural model of memory and the LR/SC reservation.
module tb_rv32i_amo_unit;

   localparam logic [4:0] F_ADD  = 5'b00000;
   localparam logic [4:0] F_SWAP = 5'b00001;
   localparam logic [4:0] F_LR   = 5'b00010;
   localparam logic [4:0] F_SC   = 5'b00011;
   localparam logic [4:0] F_XOR  = 5'b00100;
   localparam logic [4:0] F_OR   = 5'b01000;
   localparam logic [4:0] F_AND  = 5'b01100;
   localparam logic [4:0] F_MIN  = 5'b10000;
   localparam logic [4:0] F_MAX  = 5'b10100;
   localparam logic [4:0] F_MINU = 5'b11000;
   localparam logic [4:0] F_MAXU = 5'b11100;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [4:0]  funct5 = '0;
   logic [31:0] addr = '0;
   logic [31:0] rs2_data = '0;
   logic        busy, done, err, mem_req, mem_we;
   logic [31:0] rd_data, mem_addr, mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic        mem_ready = 1'b1;
   logic        snoop_valid = 1'b0;
   logic [31:0] snoop_addr = '0;

   int nCompared = 0;
   int nMismatched = 0;

   logic [31:0] memArr [0:1023];
   logic [31:0] refMem [0:1023];
   int          waitCfg = 0;
   int          waitCnt = 0;
   bit          resValid = 1'b0;
   logic [31:0] resAddr = '0;

   rv32i_amo_unit #(.XLEN(32), .ADDR_W(32), .LRSC_EN(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .funct5(funct5), .addr(addr),
      .rs2_data(rs2_data), .busy(busy), .done(done), .rd_data(rd_data), .err(err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .snoop_valid(snoop_valid), .snoop_addr(snoop_addr)
   );

   always #5 clk = ~clk;

   // Memory responder: drives ready/rdata away from the edge, inserting waitCfg stalls per phase
   always @(negedge clk) begin
      if (mem_req && waitCnt < waitCfg) begin
         mem_ready = 1'b0;
         waitCnt++;
      end else begin
         mem_ready = 1'b1;
      end
      mem_rdata = memArr[mem_addr[11:2]];
   end

   // Memory responder: commit accepted writes on the handshake edge
   always @(posedge clk) begin
      if (rst_n && mem_req && mem_ready) begin
         if (mem_we) memArr[mem_addr[11:2]] = mem_wdata;
         waitCnt = 0;
      end
   end

   function automatic bit legalRef(input logic [4:0] f);
      return f inside {F_ADD, F_SWAP, F_LR, F_SC, F_XOR, F_OR, F_AND,
                       F_MIN, F_MAX, F_MINU, F_MAXU};
   endfunction

   function automatic logic [31:0] amoRef(input logic [4:0] f, input logic [31:0] oldV, input logic [31:0] src);
      int so;
      int ss;
      so = oldV;
      ss = src;
      case (f)
         F_ADD:  return oldV + src;
         F_SWAP: return src;
         F_XOR:  return oldV ^ src;
         F_OR:   return oldV | src;
         F_AND:  return oldV & src;
         F_MIN:  return (ss < so) ? src : oldV;
         F_MAX:  return (ss > so) ? src : oldV;
         F_MINU: return (src < oldV) ? src : oldV;
         F_MAXU: return (src > oldV) ? src : oldV;
         default: return 32'h0;
      endcase
   endfunction

   task automatic setMem(input logic [31:0] a, input logic [31:0] v);
      memArr[a[11:2]] = v;
      refMem[a[11:2]] = v;
   endtask

   // Reference model of one operation: expected result, error, latency, memory access
   task automatic predict(input logic [4:0] f, input logic [31:0] a, input logic [31:0] d, input int w,
                          output logic [31:0] eRd, output bit eErr, output int eLat, output bit eAcc);
      logic [9:0]  idx;
      logic [31:0] oldV;
      bit          scOk;
      idx  = a[11:2];
      oldV = refMem[idx];
      eRd = '0; eErr = 1'b0; eLat = 2; eAcc = 1'b0;
      scOk = resValid && (resAddr == a);
      if (f == F_SC) resValid = 1'b0;
      if (a[1:0] != 2'b00 || !legalRef(f)) begin
         eErr = 1'b1;
      end else if (f == F_SC) begin
         if (scOk) begin
            refMem[idx] = d; eLat = 3 + w; eAcc = 1'b1;
         end else begin
            eRd = 32'd1;
         end
      end else if (f == F_LR) begin
         eRd = oldV; resValid = 1'b1; resAddr = a; eLat = 3 + w; eAcc = 1'b1;
      end else begin
         eRd = oldV;
         refMem[idx] = amoRef(f, oldV, d);
         if (resValid && resAddr[31:2] == a[31:2]) resValid = 1'b0;
         eLat = 4 + 2 * w; eAcc = 1'b1;
      end
   endtask

   task automatic doSnoop(input logic [31:0] a);
      @(negedge clk);
      snoop_valid = 1'b1;
      snoop_addr  = a;
      @(negedge clk);
      snoop_valid = 1'b0;
      if (resValid && resAddr[31:2] == a[31:2]) resValid = 1'b0;
   endtask

   // Issue one operation and watch it until done or a cycle budget expires
   task automatic doOp(input logic [4:0] f, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rdOut, output logic errOut, output int lat,
                       output bit sawReq, output bit unstable);
      bit          pReq;
      logic        pWe;
      logic [31:0] pAddr;
      logic [31:0] pWdata;
      pReq = 1'b0; pWe = 1'b0; pAddr = '0; pWdata = '0;
      @(negedge clk);
      start = 1'b1; funct5 = f; addr = a; rs2_data = d;
      @(negedge clk);
      start = 1'b0;
      lat = 1; sawReq = 1'b0; unstable = 1'b0;
      while (!done && lat < 60) begin
         if (mem_req) begin
            sawReq = 1'b1;
            if (pReq && pWe == mem_we &&
                (mem_addr !== pAddr || (mem_we && mem_wdata !== pWdata))) unstable = 1'b1;
            pReq = 1'b1; pWe = mem_we; pAddr = mem_addr; pWdata = mem_wdata;
         end else begin
            pReq = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      if (mem_req) sawReq = 1'b1;
      rdOut = rd_data;
      errOut = err;
      if (!done) lat = -1;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      nCompared++; if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
      nCompared++; if (done !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_done: got %b want 0", done); end
      nCompared++; if (mem_req !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_mem_req: got %b want 0", mem_req); end
      nCompared++; if (mem_we !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_mem_we: got %b want 0", mem_we); end
      nCompared++; if (err !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_err: got %b want 0", err); end
      nCompared++; if (rd_data !== 32'h0) begin nMismatched++; $display("[TB] FAIL reset_rd_data: got %h want 0", rd_data); end
      nCompared++; if (mem_addr !== 32'h0) begin nMismatched++; $display("[TB] FAIL reset_mem_addr: got %h want 0", mem_addr); end
      nCompared++; if (mem_wdata !== 32'h0) begin nMismatched++; $display("[TB] FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
      rst_n = 1'b1;
   endtask

   task automatic test_amoadd();
      logic [31:0] rd, eRd; logic e; bit eErr, eAcc, sawReq, unst; int lat, eLat;
      waitCfg = 0;
      setMem(32'h100, 32'd5);
      predict(F_ADD, 32'h100, 32'd7, 0, eRd, eErr, eLat, eAcc);
      doOp(F_ADD, 32'h100, 32'd7, rd, e, lat, sawReq, unst);
      nCompared++; if (rd !== 32'd5) begin nMismatched++; $display("[TB] FAIL amoadd_rd: got %h want 5", rd); end
      nCompared++; if (e !== 1'b0) begin nMismatched++; $display("[TB] FAIL amoadd_err: got %b want 0", e); end
      nCompared++; if (memArr[32'h100 >> 2] !== 32'd12) begin nMismatched++; $display("[TB] FAIL amoadd_mem: got %h want c", memArr[32'h100 >> 2]); end
      nCompared++; if (lat !== 4) begin nMismatched++; $display("[TB] FAIL amoadd_latency: got %0d want 4", lat); end
   endtask

   task automatic test_signed_unsigned();
      logic [4:0]  ops [3];
      logic [31:0] wants [3];
      logic [31:0] rd, eRd; logic e; bit eErr, eAcc, sawReq, unst; int lat, eLat;
      ops = '{F_MIN, F_MINU, F_MAXU};
      wants = '{32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFF};
      for (int i = 0; i < 3; i++) begin
         setMem(32'h110, 32'hFFFF_FFFF);
         predict(ops[i], 32'h110, 32'h1, 0, eRd, eErr, eLat, eAcc);
         doOp(ops[i], 32'h110, 32'h1, rd, e, lat, sawReq, unst);
         nCompared++; if (memArr[32'h110 >> 2] !== wants[i]) begin nMismatched++; $display("[TB] FAIL cmp_mem op=%b: got %h want %h", ops[i], memArr[32'h110 >> 2], wants[i]); end
         nCompared++; if (rd !== 32'hFFFF_FFFF) begin nMismatched++; $display("[TB] FAIL cmp_rd op=%b: got %h want ffffffff", ops[i], rd); end
      end
   endtask

   task automatic test_lrsc();
      logic [31:0] rd, eRd; logic e; bit eErr, eAcc, sawReq, unst; int lat, eLat;
      setMem(32'h200, 32'h55);
      predict(F_LR, 32'h200, 32'h0, 0, eRd, eErr, eLat, eAcc);
      doOp(F_LR, 32'h200, 32'h0, rd, e, lat, sawReq, unst);
      nCompared++; if (rd !== 32'h55) begin nMismatched++; $display("[TB] FAIL lr_rd: got %h want 55", rd); end
      nCompared++; if (lat !== 3) begin nMismatched++; $display("[TB] FAIL lr_latency: got %0d want 3", lat); end
      predict(F_SC, 32'h200, 32'd9, 0, eRd, eErr, eLat, eAcc);
      doOp(F_SC, 32'h200, 32'd9, rd, e, lat, sawReq, unst);
      nCompared++; if (rd !== 32'd0) begin nMismatched++; $display("[TB] FAIL sc_ok_rd: got %h want 0", rd); end
      nCompared++; if (memArr[32'h200 >> 2] !== 32'd9) begin nMismatched++; $display("[TB] FAIL sc_ok_mem: got %h want 9", memArr[32'h200 >> 2]); end
      nCompared++; if (lat !== 3) begin nMismatched++; $display("[TB] FAIL sc_ok_latency: got %0d want 3", lat); end
      predict(F_SC, 32'h200, 32'd7, 0, eRd, eErr, eLat, eAcc);
      doOp(F_SC, 32'h200, 32'd7, rd, e, lat, sawReq, unst);
      nCompared++; if (rd !== 32'd1) begin nMismatched++; $display("[TB] FAIL sc_again_rd: got %h want 1", rd); end
      nCompared++; if (sawReq !== 1'b0) begin nMismatched++; $display("[TB] FAIL sc_again_req: got %b want 0", sawReq); end
      predict(F_LR, 32'h200, 32'h0, 0, eRd, eErr, eLat, eAcc);
      doOp(F_LR, 32'h200, 32'h0, rd, e, lat, sawReq, unst);
      doSnoop(32'h202);
      predict(F_SC, 32'h200, 32'hA, 0, eRd, eErr, eLat, eAcc);
      doOp(F_SC, 32'h200, 32'hA, rd, e, lat, sawReq, unst);
      nCompared++; if (rd !== 32'd1) begin nMismatched++; $display("[TB] FAIL sc_snoop_rd: got %h want 1", rd); end
      nCompared++; if (sawReq !== 1'b0) begin nMismatched++; $display("[TB] FAIL sc_snoop_req: got %b want 0", sawReq); end
      nCompared++; if (lat !== 2) begin nMismatched++; $display("[TB] FAIL sc_snoop_latency: got %0d want 2", lat); end
      nCompared++; if (memArr[32'h200 >> 2] !== 32'd9) begin nMismatched++; $display("[TB] FAIL sc_snoop_mem: got %h want 9", memArr[32'h200 >> 2]); end
   endtask

   task automatic test_errors();
      logic [4:0]  fs [2];
      logic [31:0] as [2];
      logic [31:0] rd, eRd; logic e; bit eErr, eAcc, sawReq, unst; int lat, eLat;
      fs = '{F_SWAP, 5'b00101};
      as = '{32'h102, 32'h100};
      for (int i = 0; i < 2; i++) begin
         predict(fs[i], as[i], 32'hDEAD_BEEF, 0, eRd, eErr, eLat, eAcc);
         doOp(fs[i], as[i], 32'hDEAD_BEEF, rd, e, lat, sawReq, unst);
         nCompared++; if (e !== 1'b1) begin nMismatched++; $display("[TB] FAIL error_err case %0d: got %b want 1", i, e); end
         nCompared++; if (lat !== 2) begin nMismatched++; $display("[TB] FAIL error_latency case %0d: got %0d want 2", i, lat); end
         nCompared++; if (rd !== 32'h0) begin nMismatched++; $display("[TB] FAIL error_rd case %0d: got %h want 0", i, rd); end
         nCompared++; if (sawReq !== 1'b0) begin nMismatched++; $display("[TB] FAIL error_req case %0d: got %b want 0", i, sawReq); end
      end
   endtask

   task automatic test_wait_states();
      logic [31:0] rd, eRd; logic e; bit eErr, eAcc, sawReq, unst; int lat, eLat;
      waitCfg = 3;
      setMem(32'h180, 32'h0F0);
      predict(F_OR, 32'h180, 32'h00F, 3, eRd, eErr, eLat, eAcc);
      doOp(F_OR, 32'h180, 32'h00F, rd, e, lat, sawReq, unst);
      nCompared++; if (lat !== 10) begin nMismatched++; $display("[TB] FAIL wait_latency: got %0d want 10", lat); end
      nCompared++; if (unst !== 1'b0) begin nMismatched++; $display("[TB] FAIL wait_stable: got %b want 0", unst); end
      nCompared++; if (rd !== 32'h0F0) begin nMismatched++; $display("[TB] FAIL wait_rd: got %h want f0", rd); end
      nCompared++; if (memArr[32'h180 >> 2] !== 32'h0FF) begin nMismatched++; $display("[TB] FAIL wait_mem: got %h want ff", memArr[32'h180 >> 2]); end
      waitCfg = 0;
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd1, rd2, eRd; logic e; bit eErr, eAcc, sawReq, unst; int lat1, lat2, eLat;
      setMem(32'h120, 32'd10);
      predict(F_ADD, 32'h120, 32'd3, 0, eRd, eErr, eLat, eAcc);
      doOp(F_ADD, 32'h120, 32'd3, rd1, e, lat1, sawReq, unst);
      predict(F_ADD, 32'h120, 32'd4, 0, eRd, eErr, eLat, eAcc);
      doOp(F_ADD, 32'h120, 32'd4, rd2, e, lat2, sawReq, unst);
      nCompared++; if (rd1 !== 32'd10) begin nMismatched++; $display("[TB] FAIL b2b_rd1: got %h want a", rd1); end
      nCompared++; if (rd2 !== 32'd13) begin nMismatched++; $display("[TB] FAIL b2b_rd2: got %h want d", rd2); end
      nCompared++; if (lat2 !== 4) begin nMismatched++; $display("[TB] FAIL b2b_latency: got %0d want 4", lat2); end
      nCompared++; if (memArr[32'h120 >> 2] !== 32'd17) begin nMismatched++; $display("[TB] FAIL b2b_mem: got %h want 11", memArr[32'h120 >> 2]); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd, eRd; logic e; bit eErr, eAcc, sawReq, unst, sawDone, inWrite; int lat, eLat;
      waitCfg = 2;
      setMem(32'h140, 32'd20);
      @(negedge clk);
      start = 1'b1; funct5 = F_ADD; addr = 32'h140; rs2_data = 32'd1;
      @(negedge clk);
      start = 1'b0;
      inWrite = 1'b0;
      for (int i = 0; i < 20 && !inWrite; i++) begin
         if (mem_req && mem_we) inWrite = 1'b1;
         else @(negedge clk);
      end
      nCompared++; if (inWrite !== 1'b1 || busy !== 1'b1) begin nMismatched++; $display("[TB] FAIL midreset_reach_write: got write=%b busy=%b want 1 1", inWrite, busy); end
      #2 rst_n = 1'b0;
      #1;
      nCompared++; if (mem_req !== 1'b0) begin nMismatched++; $display("[TB] FAIL midreset_mem_req: got %b want 0", mem_req); end
      nCompared++; if (busy !== 1'b0 || mem_we !== 1'b0) begin nMismatched++; $display("[TB] FAIL midreset_outputs: got busy=%b we=%b want 0 0", busy, mem_we); end
      waitCnt = 0;
      waitCfg = 0;
      resValid = 1'b0;
      sawDone = 1'b0;
      repeat (2) begin
         @(negedge clk);
         if (done) sawDone = 1'b1;
      end
      rst_n = 1'b1;
      repeat (2) begin
         @(negedge clk);
         if (done) sawDone = 1'b1;
      end
      nCompared++; if (sawDone !== 1'b0) begin nMismatched++; $display("[TB] FAIL midreset_no_done: got %b want 0", sawDone); end
      nCompared++; if (memArr[32'h140 >> 2] !== 32'd20) begin nMismatched++; $display("[TB] FAIL midreset_mem_untouched: got %h want 14", memArr[32'h140 >> 2]); end
      predict(F_ADD, 32'h140, 32'd5, 0, eRd, eErr, eLat, eAcc);
      doOp(F_ADD, 32'h140, 32'd5, rd, e, lat, sawReq, unst);
      nCompared++; if (rd !== 32'd20 || e !== 1'b0) begin nMismatched++; $display("[TB] FAIL midreset_after_rd: got %h err=%b want 14 err=0", rd, e); end
      nCompared++; if (memArr[32'h140 >> 2] !== 32'd25) begin nMismatched++; $display("[TB] FAIL midreset_after_mem: got %h want 19", memArr[32'h140 >> 2]); end
   endtask

   task automatic test_random();
      logic [4:0]  legalOps [11];
      logic [4:0]  illegalOps [3];
      logic [4:0]  f;
      logic [31:0] a, d, rd, eRd, lastLrAddr;
      logic        e;
      bit          eErr, eAcc, sawReq, unst, lastWasLr;
      int          lat, eLat, w;
      legalOps = '{F_ADD, F_SWAP, F_LR, F_SC, F_XOR, F_OR, F_AND, F_MIN, F_MAX, F_MINU, F_MAXU};
      illegalOps = '{5'b00101, 5'b11111, 5'b00110};
      lastWasLr = 1'b0;
      lastLrAddr = '0;
      for (int k = 0; k < 8; k++) setMem(32'h300 + 32'(k * 4), $urandom);
      for (int n = 0; n < 60; n++) begin
         int r;
         r = $urandom_range(0, 13);
         f = (r < 11) ? legalOps[r] : illegalOps[r - 11];
         a = 32'h300 + 32'($urandom_range(0, 7) * 4);
         if ($urandom_range(0, 9) == 0) a = a + 32'($urandom_range(1, 3));
         if (lastWasLr && $urandom_range(0, 1) == 1) begin
            f = F_SC;
            a = lastLrAddr;
         end
         d = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
         w = $urandom_range(0, 2);
         waitCfg = w;
         if ($urandom_range(0, 5) == 0) doSnoop(32'h300 + 32'($urandom_range(0, 31)));
         predict(f, a, d, w, eRd, eErr, eLat, eAcc);
         doOp(f, a, d, rd, e, lat, sawReq, unst);
         nCompared++; if (rd !== eRd) begin nMismatched++; $display("[TB] FAIL rand_rd #%0d f=%b a=%h: got %h want %h", n, f, a, rd, eRd); end
         nCompared++; if (e !== eErr) begin nMismatched++; $display("[TB] FAIL rand_err #%0d f=%b a=%h: got %b want %b", n, f, a, e, eErr); end
         nCompared++; if (lat !== eLat) begin nMismatched++; $display("[TB] FAIL rand_latency #%0d f=%b a=%h: got %0d want %0d", n, f, a, lat, eLat); end
         nCompared++; if (sawReq !== eAcc) begin nMismatched++; $display("[TB] FAIL rand_access #%0d f=%b a=%h: got %b want %b", n, f, a, sawReq, eAcc); end
         nCompared++; if (memArr[a[11:2]] !== refMem[a[11:2]]) begin nMismatched++; $display("[TB] FAIL rand_mem #%0d f=%b a=%h: got %h want %h", n, f, a, memArr[a[11:2]], refMem[a[11:2]]); end
         lastWasLr = (f == F_LR) && !eErr;
         if (lastWasLr) lastLrAddr = a;
      end
      waitCfg = 0;
   endtask

   // Global time limit so a stuck design still ends the run
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got no completion want completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Test sequence
   initial begin
      for (int i = 0; i < 1024; i++) begin
         memArr[i] = '0;
         refMem[i] = '0;
      end
      test_reset();
      test_amoadd();
      test_signed_unsigned();
      test_lrsc();
      test_errors();
      test_wait_states();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
